eth_xcvr_reconfig_bridge: RTL and testbench

- APB-slave to multi-channel Avalon-MM transceiver-reconfig bridge; sits directly downstream of the Ethernet adaptation sequencer's APB master.
- Decodes a channel index from paddr and issues one Avalon-MM read or write to that channel's reconfig port.
- Returns read data, enforces a waitrequest/readdatavalid timeout, and reports errors on pserr.

---
 rtl/eth_xcvr_reconfig_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_eth_xcvr_reconfig_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_xcvr_reconfig_bridge.sv
// APB slave to multi-channel Avalon-MM transceiver reconfig bridge.
// Each APB transfer becomes one AVMM read/write on the channel selected by paddr.
module eth_xcvr_reconfig_bridge #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CH_LSB      = 16,
  parameter int unsigned AVMM_AW     = 11,
  parameter bit          USE_RDVALID = 1'b0,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   penable,
  input  logic [31:0]            paddr,
  input  logic                   pwrite,
  input  logic [31:0]            pwdata,
  output logic                   pready,
  output logic [31:0]            prdata,
  output logic                   pserr,
  output logic [NUM_CH-1:0]      avmm_read,
  output logic [NUM_CH-1:0]      avmm_write,
  output logic [AVMM_AW-1:0]     avmm_address,
  output logic [31:0]            avmm_writedata,
  input  logic [32*NUM_CH-1:0]   avmm_readdata,
  input  logic [NUM_CH-1:0]      avmm_waitrequest,
  input  logic [NUM_CH-1:0]      avmm_readdatavalid,
  output logic [15:0]            stat_err_cnt,
  output logic [1:0]             stat_err_code,
  output logic [31:0]            stat_last_err_addr,
  output logic                   stat_busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_BADCH   = 2'd2;

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYC);

  logic [1:0]        r_state,   w_state_nxt;
  logic [31:0]       r_paddr,   w_paddr_nxt;
  logic              r_write,   w_write_nxt;
  logic [31:0]       r_wdata,   w_wdata_nxt;
  logic              r_bad,     w_bad_nxt;
  logic [15:0]       r_timer,   w_timer_nxt;
  logic [NUM_CH-1:0] r_rd,      w_rd_nxt;
  logic [NUM_CH-1:0] r_wr,      w_wr_nxt;
  logic              r_pready,  w_pready_nxt;
  logic              r_pserr,   w_pserr_nxt;
  logic [31:0]       r_prdata,  w_prdata_nxt;
  logic [15:0]       r_err_cnt, w_err_cnt_nxt;
  logic [1:0]        r_err_code, w_err_code_nxt;
  logic [31:0]       r_err_addr, w_err_addr_nxt;
  logic              r_busy,    w_busy_nxt;

  logic [3:0]        w_req_ch;
  logic              w_req_ok;
  logic [NUM_CH-1:0] w_req_onehot;
  logic [3:0]        w_cur_ch;
  logic              w_sel_wait;
  logic              w_sel_rdv;
  logic [31:0]       w_sel_rdata;
  logic [16:0]       w_timer_inc;
  logic              w_to;
  logic              w_err_set;
  logic [1:0]        w_err_code_new;

  assign w_req_ch     = paddr[CH_LSB +: 4];
  assign w_req_ok     = 32'(w_req_ch) < NUM_CH;
  assign w_req_onehot = w_req_ok ? (NUM_CH'(1) << w_req_ch) : '0;
  assign w_cur_ch     = r_paddr[CH_LSB +: 4];
  assign w_timer_inc  = 17'(r_timer) + 17'd1;
  assign w_to         = (w_timer_inc == TO_LIM);

  // Only the latched channel's handshake inputs are visible to the FSM.
  always_comb begin
    w_sel_wait  = 1'b1;
    w_sel_rdv   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (w_cur_ch == 4'(i)) begin
        w_sel_wait  = avmm_waitrequest[i];
        w_sel_rdv   = avmm_readdatavalid[i];
        w_sel_rdata = avmm_readdata[32*i +: 32];
      end
    end
  end

  // Bad channels spend one strobe-less cycle in REQ so errors share the minimum response latency.
  always_comb begin
    w_state_nxt    = r_state;
    w_paddr_nxt    = r_paddr;
    w_write_nxt    = r_write;
    w_wdata_nxt    = r_wdata;
    w_bad_nxt      = r_bad;
    w_timer_nxt    = r_timer;
    w_rd_nxt       = r_rd;
    w_wr_nxt       = r_wr;
    w_pready_nxt   = 1'b0;
    w_pserr_nxt    = 1'b0;
    w_prdata_nxt   = '0;
    w_err_set      = 1'b0;
    w_err_code_new = ERR_TIMEOUT;
    case (r_state)
      S_IDLE: begin
        if (psel && penable) begin
          w_paddr_nxt = paddr;
          w_write_nxt = pwrite;
          w_wdata_nxt = pwdata;
          w_timer_nxt = '0;
          w_bad_nxt   = !w_req_ok;
          w_rd_nxt    = pwrite ? '0 : w_req_onehot;
          w_wr_nxt    = pwrite ? w_req_onehot : '0;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_timer_nxt = w_timer_inc[15:0];
        if (r_bad) begin
          w_state_nxt    = S_RESP;
          w_pready_nxt   = 1'b1;
          w_pserr_nxt    = 1'b1;
          w_err_set      = 1'b1;
          w_err_code_new = ERR_BADCH;
        end else if (!w_sel_wait) begin
          w_rd_nxt = '0;
          w_wr_nxt = '0;
          if (!r_write && USE_RDVALID) begin
            w_state_nxt = S_RDWAIT;
          end else begin
            w_state_nxt  = S_RESP;
            w_pready_nxt = 1'b1;
            w_prdata_nxt = r_write ? 32'h0 : w_sel_rdata;
          end
        end else if (w_to) begin
          w_rd_nxt     = '0;
          w_wr_nxt     = '0;
          w_state_nxt  = S_RESP;
          w_pready_nxt = 1'b1;
          w_pserr_nxt  = 1'b1;
          w_err_set    = 1'b1;
        end
      end
      S_RDWAIT: begin
        w_timer_nxt = w_timer_inc[15:0];
        if (w_sel_rdv) begin
          w_state_nxt  = S_RESP;
          w_pready_nxt = 1'b1;
          w_prdata_nxt = w_sel_rdata;
        end else if (w_to) begin
          w_state_nxt  = S_RESP;
          w_pready_nxt = 1'b1;
          w_pserr_nxt  = 1'b1;
          w_err_set    = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_err_cnt_nxt  = r_err_cnt;
    w_err_code_nxt = r_err_code;
    w_err_addr_nxt = r_err_addr;
    if (w_err_set) begin
      w_err_code_nxt = w_err_code_new;
      w_err_addr_nxt = r_paddr;
      if (r_err_cnt != 16'hFFFF) w_err_cnt_nxt = r_err_cnt + 16'd1;
    end
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_paddr    <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_bad      <= 1'b0;
      r_timer    <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_pready   <= 1'b0;
      r_pserr    <= 1'b0;
      r_prdata   <= '0;
      r_err_cnt  <= '0;
      r_err_code <= '0;
      r_err_addr <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_paddr    <= w_paddr_nxt;
      r_write    <= w_write_nxt;
      r_wdata    <= w_wdata_nxt;
      r_bad      <= w_bad_nxt;
      r_timer    <= w_timer_nxt;
      r_rd       <= w_rd_nxt;
      r_wr       <= w_wr_nxt;
      r_pready   <= w_pready_nxt;
      r_pserr    <= w_pserr_nxt;
      r_prdata   <= w_prdata_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
      r_err_code <= w_err_code_nxt;
      r_err_addr <= w_err_addr_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign pready             = r_pready;
  assign prdata             = r_prdata;
  assign pserr              = r_pserr;
  assign avmm_read          = r_rd;
  assign avmm_write         = r_wr;
  assign avmm_address       = r_paddr[2 +: AVMM_AW];
  assign avmm_writedata     = r_wdata;
  assign stat_err_cnt       = r_err_cnt;
  assign stat_err_code      = r_err_code;
  assign stat_last_err_addr = r_err_addr;
  assign stat_busy          = r_busy;

endmodule

// File: tb/tb_eth_xcvr_reconfig_bridge.sv
// Bench for eth_xcvr_reconfig_bridge: two instances (plain capture and readdatavalid mode)
// driven by directed and random transfers, checked against a transfer-level timing model.
module tb_eth_xcvr_reconfig_bridge;

  localparam int unsigned NCH = 4;
  localparam int          TO  = 16;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] psel;
  logic penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [32*NCH-1:0] rdata_i;
  logic [NCH-1:0] wreq_i, rdv_i;

  logic            pready_o [2];
  logic [31:0]     prdata_o [2];
  logic            pserr_o  [2];
  logic [NCH-1:0]  rd_o     [2];
  logic [NCH-1:0]  wr_o     [2];
  logic [10:0]     addr_o   [2];
  logic [31:0]     wd_o     [2];
  logic [15:0]     cnt_o    [2];
  logic [1:0]      code_o   [2];
  logic [31:0]     eaddr_o  [2];
  logic            busy_o   [2];

  logic [15:0] m_cnt   [2];
  logic [1:0]  m_code  [2];
  logic [31:0] m_eaddr [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  eth_xcvr_reconfig_bridge #(.NUM_CH(NCH), .CH_LSB(16), .AVMM_AW(11), .USE_RDVALID(1'b0),
                             .TIMEOUT_CYC(TO)) dut0 (
    .clk(clk), .rst(rst), .psel(psel[0]), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready_o[0]), .prdata(prdata_o[0]), .pserr(pserr_o[0]),
    .avmm_read(rd_o[0]), .avmm_write(wr_o[0]), .avmm_address(addr_o[0]),
    .avmm_writedata(wd_o[0]), .avmm_readdata(rdata_i), .avmm_waitrequest(wreq_i),
    .avmm_readdatavalid(rdv_i), .stat_err_cnt(cnt_o[0]), .stat_err_code(code_o[0]),
    .stat_last_err_addr(eaddr_o[0]), .stat_busy(busy_o[0]));

  eth_xcvr_reconfig_bridge #(.NUM_CH(NCH), .CH_LSB(16), .AVMM_AW(11), .USE_RDVALID(1'b1),
                             .TIMEOUT_CYC(TO)) dut1 (
    .clk(clk), .rst(rst), .psel(psel[1]), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready_o[1]), .prdata(prdata_o[1]), .pserr(pserr_o[1]),
    .avmm_read(rd_o[1]), .avmm_write(wr_o[1]), .avmm_address(addr_o[1]),
    .avmm_writedata(wd_o[1]), .avmm_readdata(rdata_i), .avmm_waitrequest(wreq_i),
    .avmm_readdatavalid(rdv_i), .stat_err_cnt(cnt_o[1]), .stat_err_code(code_o[1]),
    .stat_last_err_addr(eaddr_o[1]), .stat_busy(busy_o[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic noise();
    wreq_i = NCH'($urandom);
    rdv_i  = NCH'($urandom);
    for (int i = 0; i < int'(NCH); i++) rdata_i[32*i +: 32] = $urandom;
  endtask

  // One APB transfer on instance d. Waitrequest is released in strobe cycle wdel+1,
  // readdatavalid comes vdel cycles into the read-wait phase.
  task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input int wdel, input int vdel,
                      input logic [31:0] rdata, input string tag);
    int ch, exp_strb, exp_prdy, cap_cyc, got, bad_strb, bad_bus;
    logic bad, exp_err, busy1, o_pserr;
    logic [1:0] exp_code, o_code;
    logic [31:0] exp_data, o_prdata, o_eaddr;
    logic [15:0] o_cnt;
    logic [NCH-1:0] onehot, exp_rd, exp_wr;

    ch     = int'(addr[19:16]);
    bad    = (ch >= int'(NCH));
    onehot = bad ? '0 : (NCH'(1) << ch);
    exp_code = 2'd1;
    exp_data = 32'h0;
    if (bad) begin
      exp_strb = 0; exp_prdy = 2; exp_err = 1'b1; exp_code = 2'd2;
    end else if (wdel + 1 > TO) begin
      exp_strb = TO; exp_prdy = TO + 1; exp_err = 1'b1;
    end else if (wr || d == 0) begin
      exp_strb = wdel + 1; exp_prdy = wdel + 2; exp_err = 1'b0;
      exp_data = wr ? 32'h0 : rdata;
    end else if (wdel + vdel + 2 <= TO) begin
      exp_strb = wdel + 1; exp_prdy = wdel + vdel + 3; exp_err = 1'b0; exp_data = rdata;
    end else begin
      exp_strb = wdel + 1; exp_prdy = TO + 1; exp_err = 1'b1;
    end
    if (exp_err) begin
      if (m_cnt[d] != 16'hFFFF) m_cnt[d] = m_cnt[d] + 16'd1;
      m_code[d]  = exp_code;
      m_eaddr[d] = addr;
    end
    cap_cyc = (wr || d == 0) ? wdel + 1 : wdel + vdel + 2;

    got = -1; bad_strb = 0; bad_bus = 0; busy1 = 1'b0;
    o_prdata = 'x; o_pserr = 1'bx; o_cnt = 'x; o_code = 'x; o_eaddr = 'x;
    psel[d] = 1'b1; penable = 1'b1; paddr = addr; pwrite = wr; pwdata = wdata;
    noise();
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      exp_rd = (k <= exp_strb && !wr) ? onehot : '0;
      exp_wr = (k <= exp_strb &&  wr) ? onehot : '0;
      if (rd_o[d] !== exp_rd || wr_o[d] !== exp_wr) bad_strb++;
      if (k <= exp_strb && (addr_o[d] !== addr[12:2] || (wr && wd_o[d] !== wdata))) bad_bus++;
      if (k == 1) busy1 = busy_o[d];
      if (pready_o[d] === 1'b1) begin
        got = k;
        o_prdata = prdata_o[d]; o_pserr = pserr_o[d];
        o_cnt = cnt_o[d]; o_code = code_o[d]; o_eaddr = eaddr_o[d];
        psel[d] = 1'b0; penable = 1'b0;
        break;
      end
      noise();
      if (!bad) begin
        if (k <= wdel) wreq_i[ch] = 1'b1;
        else if (k == wdel + 1) wreq_i[ch] = 1'b0;
        rdv_i[ch] = (k == cap_cyc);
        if (k == cap_cyc) rdata_i[32*ch +: 32] = rdata;
      end
    end
    if (got < 0) begin
      psel[d] = 1'b0; penable = 1'b0;
    end
    chk({tag, ":pready_cycle"}, got, exp_prdy);
    chk({tag, ":strobes"}, bad_strb, 0);
    chk({tag, ":addr_wdata"}, bad_bus, 0);
    chk({tag, ":busy"}, busy1, 1'b1);
    chk({tag, ":prdata"}, o_prdata, exp_data);
    chk({tag, ":pserr"}, o_pserr, exp_err);
    chk({tag, ":err_cnt"}, o_cnt, m_cnt[d]);
    chk({tag, ":err_code"}, o_code, m_code[d]);
    chk({tag, ":err_addr"}, o_eaddr, m_eaddr[d]);
    @(negedge clk);
    chk({tag, ":after_resp"}, {pready_o[d], pserr_o[d], busy_o[d]}, 3'b000);
    chk({tag, ":prdata_clr"}, prdata_o[d], 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int d;
    rst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    rdata_i = '0; wreq_i = '1; rdv_i = '0;
    for (int i = 0; i < 2; i++) begin m_cnt[i] = '0; m_code[i] = '0; m_eaddr[i] = '0; end

    @(negedge clk);
    chk("reset:apb", {pready_o[0], pserr_o[0], busy_o[0]}, 3'b000);
    chk("reset:prdata", prdata_o[0], 32'h0);
    chk("reset:strobes", {rd_o[0], wr_o[0], rd_o[1], wr_o[1]}, 0);
    chk("reset:stats", {cnt_o[0], code_o[0]}, 0);
    chk("reset:bus", {addr_o[0], wd_o[0]}, 0);
    rst = 1'b0;
    @(negedge clk);

    xfer(0, 32'h0001_0210, 1'b1, 32'h0000_00A5, 3, 0, 32'h0, "wr_ch1");
    xfer(0, 32'h0002_0040, 1'b0, 32'h0, 2, 0, 32'h0000_005C, "rd_ch2");
    xfer(1, 32'h0002_0040, 1'b0, 32'h0, 2, 2, 32'h0000_005C, "rd_ch2_rdv");
    xfer(0, 32'h0005_0100, 1'b0, 32'h0, 0, 0, 32'h0, "bad_ch5");
    xfer(0, 32'h0000_0008, 1'b1, 32'h1234_5678, 100, 0, 32'h0, "to_wr");
    xfer(0, 32'h0000_000C, 1'b0, 32'h0, 100, 0, 32'hDEAD_BEEF, "to_rd");
    xfer(0, 32'h0000_0010, 1'b0, 32'h0, 15, 0, 32'hCAFE_0001, "edge_ok");
    xfer(0, 32'h0000_0014, 1'b1, 32'h5555_AAAA, 16, 0, 32'h0, "edge_to");
    xfer(1, 32'h0003_0020, 1'b0, 32'h0, 5, 9, 32'h0BAD_F00D, "rdv_edge_ok");
    xfer(1, 32'h0003_0024, 1'b0, 32'h0, 5, 10, 32'h1111_2222, "rdv_edge_to");

    for (int i = 0; i < 4; i++) begin
      a = {12'h000, (i % 2 == 1) ? 4'd3 : 4'd0, 16'(16'h0100 + i * 4)};
      xfer(0, a, i < 2, $urandom, i, 0, $urandom, "b2b");
    end

    for (int i = 0; i < 24; i++) begin
      d = int'($urandom_range(0, 1));
      a = $urandom;
      a[19:16] = 4'($urandom_range(0, 5));
      xfer(d, a, 1'($urandom), $urandom, int'($urandom_range(0, 18)),
           int'($urandom_range(0, 9)), $urandom, "rand");
    end

    // abort a transfer while its strobe is held by waitrequest
    psel[0] = 1'b1; penable = 1'b1; paddr = 32'h0001_0020; pwrite = 1'b1; pwdata = 32'h77;
    wreq_i = '1;
    repeat (3) @(negedge clk);
    chk("rst_mid:strobe_pre", wr_o[0], 4'b0010);
    rst = 1'b1;
    #1;
    chk("rst_mid:strobes", {rd_o[0], wr_o[0]}, 0);
    chk("rst_mid:apb", {pready_o[0], pserr_o[0], busy_o[0]}, 3'b000);
    chk("rst_mid:stats", {cnt_o[0], code_o[0]}, 0);
    chk("rst_mid:err_addr", eaddr_o[0], 32'h0);
    psel = '0; penable = 1'b0;
    for (int i = 0; i < 2; i++) begin m_cnt[i] = '0; m_code[i] = '0; m_eaddr[i] = '0; end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xfer(0, 32'h0001_0030, 1'b0, 32'h0, 1, 0, 32'hFACE_B00C, "post_rst");

    // preload the counter near the top rather than spending 65536 transfers
    force dut0.r_err_cnt = 16'hFFFD;
    @(negedge clk);
    release dut0.r_err_cnt;
    m_cnt[0] = 16'hFFFD;
    for (int i = 0; i < 4; i++) begin
      a = {12'h000, 4'(4 + i), 16'(i * 8)};
      xfer(0, a, 1'($urandom), $urandom, 0, 0, 32'h0, "sat");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
